// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out shift register.
package piso_pkg;

  // The serialiser is either waiting for a word or shifting one out.
  typedef enum logic {
    OCIOSO     = 1'b0,
    DESLOCANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/buffer_palavra.sv
// One-entry word buffer with a full flag. It holds the next word while the
// current one is still being shifted out.
module buffer_palavra #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               escrever,
  input  logic               consumir,
  input  logic [LARGURA-1:0] dado_entrada,
  output logic [LARGURA-1:0] dado,
  output logic               cheio
);

  // Capture a word on write, drop the full flag once the word is consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dado  <= '0;
      cheio <= 1'b0;
    end else if (escrever) begin
      dado  <= dado_entrada;
      cheio <= 1'b1;
    end else if (consumir) begin
      cheio <= 1'b0;
    end
  end

endmodule

// File: rtl/registrador_piso_param.sv
// Parameterised parallel-in / serial-out register. A word is accepted with a
// valid/ready handshake and shifted out one bit per enable tick. A one-word
// holding buffer allows back-to-back words with no idle cycle between them.
module registrador_piso_param
  import piso_pkg::*;
#(
  parameter int LARGURA      = 8,
  parameter bit MSB_PRIMEIRO = 1'b0,
  parameter bit NIVEL_OCIOSO = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               entrada_valida,
  input  logic [LARGURA-1:0] entrada_paralela,
  output logic               entrada_pronta,
  output logic               saida_serial,
  output logic               saida_valida,
  output logic               ultimo_bit,
  output logic               ocupado
);

  localparam int               CW     = $clog2(LARGURA);
  localparam logic [CW-1:0]    ULTIMO = CW'(LARGURA - 1);

  estado_t            estado, estado_prox;
  logic [CW-1:0]      contador, contador_prox, indice;
  logic [LARGURA-1:0] deslocador, deslocador_prox, buf_dado;
  logic               buf_cheio, aceita, fim, grava_buf, consome_buf;

  // Ready depends only on the registered full flag, never on valid or enable.
  assign entrada_pronta = ~buf_cheio;
  assign aceita         = entrada_valida & ~buf_cheio;
  assign fim            = (contador == ULTIMO);
  assign indice         = MSB_PRIMEIRO ? (ULTIMO - contador) : contador;

  buffer_palavra #(
    .LARGURA(LARGURA)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .escrever     (grava_buf),
    .consumir     (consome_buf),
    .dado_entrada (entrada_paralela),
    .dado         (buf_dado),
    .cheio        (buf_cheio)
  );

  // State, bit counter and shift register; reset wins over accept and enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado     <= OCIOSO;
      contador   <= '0;
      deslocador <= '0;
    end else begin
      estado     <= estado_prox;
      contador   <= contador_prox;
      deslocador <= deslocador_prox;
    end
  end

  // Next-state logic: load, advance, refill from the buffer or go idle.
  always_comb begin
    estado_prox     = estado;
    contador_prox   = contador;
    deslocador_prox = deslocador;
    grava_buf       = 1'b0;
    consome_buf     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (aceita) begin
          deslocador_prox = entrada_paralela;
          contador_prox   = '0;
          estado_prox     = DESLOCANDO;
        end
      end
      DESLOCANDO: begin
        // A word arriving on the last-bit tick with an empty buffer bypasses
        // the buffer and goes straight into the shift register below.
        if (aceita && !(enable && fim)) begin
          grava_buf = 1'b1;
        end
        if (enable) begin
          if (!fim) begin
            contador_prox = contador + CW'(1);
          end else begin
            contador_prox = '0;
            if (buf_cheio) begin
              deslocador_prox = buf_dado;
              consome_buf     = 1'b1;
            end else if (aceita) begin
              deslocador_prox = entrada_paralela;
            end else begin
              estado_prox = OCIOSO;
            end
          end
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Outputs come from registered state only; idle shows the configured level.
  always_comb begin
    saida_valida = 1'b0;
    ultimo_bit   = 1'b0;
    saida_serial = NIVEL_OCIOSO;
    if (estado == DESLOCANDO) begin
      saida_valida = 1'b1;
      ultimo_bit   = fim;
      saida_serial = deslocador[indice];
    end
    ocupado = (estado == DESLOCANDO) | buf_cheio;
  end

endmodule

// File: tb/tb_registrador_piso_param.sv
// Bench for registrador_piso_param: two instances (LSB-first/idle-low and
// MSB-first/idle-high) share stimulus and are compared each cycle against a
// queue-based model of accepted words, plus directed serial-stream checks.
module tb_registrador_piso_param;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         entrada_valida;
  logic [L-1:0] entrada_paralela;

  logic pronta0, serial0, valida0, ultimo0, ocupado0;
  logic pronta1, serial1, valida1, ultimo1, ocupado1;

  int n_cmp = 0;
  int n_err = 0;

  // Model: words accepted but not yet fully sent, and position in the head word.
  logic [L-1:0] fila[$];
  int           pos = 0;

  logic obs_s0, obs_s1, obs_v0, obs_u0, obs_p0, obs_o0;

  always #5 clk = ~clk;

  registrador_piso_param #(.LARGURA(L), .MSB_PRIMEIRO(1'b0), .NIVEL_OCIOSO(1'b0)) dut0 (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .entrada_valida   (entrada_valida),
    .entrada_paralela (entrada_paralela),
    .entrada_pronta   (pronta0),
    .saida_serial     (serial0),
    .saida_valida     (valida0),
    .ultimo_bit       (ultimo0),
    .ocupado          (ocupado0)
  );

  registrador_piso_param #(.LARGURA(L), .MSB_PRIMEIRO(1'b1), .NIVEL_OCIOSO(1'b1)) dut1 (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .entrada_valida   (entrada_valida),
    .entrada_paralela (entrada_paralela),
    .entrada_pronta   (pronta1),
    .saida_serial     (serial1),
    .saida_valida     (valida1),
    .ultimo_bit       (ultimo1),
    .ocupado          (ocupado1)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_cmp++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic ciclo(input logic r, input logic en, input logic v, input logic [L-1:0] d);
    logic         pronta_m;
    logic         aceito;
    logic [L-1:0] w;
    @(negedge clk);
    pronta_m = (fila.size() < 2);
    verifica("pronta0", pronta0, pronta_m);
    verifica("pronta1", pronta1, pronta_m);
    if (fila.size() == 0) begin
      verifica("valida0", valida0, 0);
      verifica("valida1", valida1, 0);
      verifica("ultimo0", ultimo0, 0);
      verifica("ultimo1", ultimo1, 0);
      verifica("ocupado0", ocupado0, 0);
      verifica("ocupado1", ocupado1, 0);
      verifica("serial0_ocioso", serial0, 0);
      verifica("serial1_ocioso", serial1, 1);
    end else begin
      w = fila[0];
      verifica("valida0", valida0, 1);
      verifica("valida1", valida1, 1);
      verifica("ultimo0", ultimo0, (pos == L - 1));
      verifica("ultimo1", ultimo1, (pos == L - 1));
      verifica("ocupado0", ocupado0, 1);
      verifica("ocupado1", ocupado1, 1);
      verifica("serial0", serial0, w[pos]);
      verifica("serial1", serial1, w[L-1-pos]);
    end
    obs_s0 = serial0; obs_s1 = serial1; obs_v0 = valida0;
    obs_u0 = ultimo0; obs_p0 = pronta0; obs_o0 = ocupado0;

    reset = r; enable = en; entrada_valida = v; entrada_paralela = d;

    if (!r) begin
      fila.delete();
      pos = 0;
    end else begin
      aceito = v && pronta_m;
      if (fila.size() > 0 && en) begin
        if (pos == L - 1) begin
          void'(fila.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (aceito) fila.push_back(d);
    end
  endtask

  initial begin
    logic [15:0] acc;
    int          n_pronta_baixa, n_valida, n_ultimo, idx, n_bits;
    logic        en, prev_en;

    reset = 1'b0; enable = 1'b0; entrada_valida = 1'b0; entrada_paralela = '0;
    repeat (2) @(posedge clk);
    fila.delete();
    pos = 0;

    // Reset state, and reset overriding a simultaneous accept.
    ciclo(1'b0, 1'b1, 1'b1, 8'hAA);
    verifica("reset_pronta", obs_p0, 1);
    verifica("reset_valida", obs_v0, 0);
    verifica("reset_ocupado", obs_o0, 0);
    verifica("reset_serial1", obs_s1, 1);
    ciclo(1'b1, 1'b1, 1'b0, 8'h00);
    verifica("reset_prio_valida", obs_v0, 0);

    // 8'h1E with enable held: LSB-first and MSB-first streams, last-bit flag.
    ciclo(1'b1, 1'b1, 1'b1, 8'h1E);
    acc = '0; n_ultimo = 0;
    for (int i = 0; i < 8; i++) begin
      ciclo(1'b1, 1'b1, 1'b0, 8'h00);
      acc[i] = obs_s0; acc[8+i] = obs_s1;
      if (obs_u0) n_ultimo++;
      if (i == 7) verifica("1E_ultimo_no_oitavo", obs_u0, 1);
    end
    verifica("1E_lsb_primeiro", acc[7:0], 8'h1E);
    verifica("1E_msb_primeiro", acc[15:8], 8'h78);
    verifica("1E_n_ultimo", n_ultimo, 1);
    ciclo(1'b1, 1'b1, 1'b0, 8'h00);
    verifica("1E_volta_ocioso", obs_v0, 0);

    // 8'h1E then 8'hFF offered on the third bit: buffered, no gap.
    ciclo(1'b1, 1'b1, 1'b1, 8'h1E);
    acc = '0; n_pronta_baixa = 0; n_valida = 0;
    for (int i = 0; i < 16; i++) begin
      ciclo(1'b1, 1'b1, (i == 2), 8'hFF);
      acc[i] = obs_s0;
      if (!obs_p0) n_pronta_baixa++;
      if (obs_v0) n_valida++;
      if (i == 7) verifica("buf_pronta_baixa_oitavo", obs_p0, 0);
      if (i == 8) verifica("buf_pronta_volta", obs_p0, 1);
    end
    verifica("buf_sequencia", acc, 16'hFF1E);
    verifica("buf_n_pronta_baixa", n_pronta_baixa, 5);
    verifica("buf_n_valida", n_valida, 16);
    ciclo(1'b1, 1'b1, 1'b0, 8'h00);

    // 8'hA5 with enable 1,0,0,...: bits held while enable is low.
    ciclo(1'b1, 1'b1, 1'b1, 8'hA5);
    acc = '0; idx = 0; prev_en = 1'b1; n_valida = 0; n_bits = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      en = (k % 3 == 0);
      ciclo(1'b1, en, 1'b0, 8'h00);
      n_bits++;
      if (obs_v0) n_valida++;
      if (prev_en) begin
        acc[idx] = obs_s0;
        idx++;
      end
      prev_en = en;
    end
    verifica("A5_sequencia", acc[7:0], 8'hA5);
    verifica("A5_valida_contínua", n_valida, n_bits);
    repeat (4) ciclo(1'b1, 1'b1, 1'b0, 8'h00);

    // Reset on the fourth bit of 8'hFF, then 8'h01 serialises cleanly.
    ciclo(1'b1, 1'b1, 1'b1, 8'hFF);
    repeat (3) ciclo(1'b1, 1'b1, 1'b0, 8'h00);
    ciclo(1'b0, 1'b1, 1'b0, 8'h00);
    verifica("rst_meio_quarto_bit", obs_v0, 1);
    ciclo(1'b1, 1'b1, 1'b1, 8'h01);
    verifica("rst_meio_valida", obs_v0, 0);
    verifica("rst_meio_serial1", obs_s1, 1);
    verifica("rst_meio_pronta", obs_p0, 1);
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      ciclo(1'b1, 1'b1, 1'b0, 8'h00);
      acc[i] = obs_s0;
    end
    verifica("rst_meio_01", acc[7:0], 8'h01);
    ciclo(1'b1, 1'b1, 1'b0, 8'h00);

    // Accept on the last-bit tick with an empty buffer: direct reload, no gap.
    ciclo(1'b1, 1'b1, 1'b1, 8'h3C);
    acc = '0; n_valida = 0;
    for (int i = 0; i < 16; i++) begin
      ciclo(1'b1, 1'b1, (i == 7), 8'hC3);
      acc[i] = obs_s0;
      if (obs_v0) n_valida++;
      if (i == 7) verifica("direto_pronta_ultimo", obs_p0, 1);
    end
    verifica("direto_sequencia", acc, 16'hC33C);
    verifica("direto_n_valida", n_valida, 16);

    // Randomised traffic, checked cycle by cycle against the queue model.
    for (int k = 0; k < 3000; k++) begin
      ciclo(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
            $urandom_range(0, 1), L'($urandom));
    end
    ciclo(1'b1, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/registrador_piso_param.md
REGISTRADOR_PISO_PARAM -- requirements
Module: registrador_piso_param

Interface
REQ-001 Parameter LARGURA, default 8: word width in bits; SHALL be >= 2.
REQ-002 Parameter MSB_PRIMEIRO, default 0: 0 = bit 0 shifted first, 1 = bit LARGURA-1 shifted first.
REQ-003 Parameter NIVEL_OCIOSO, default 0: saida_serial level whenever no bit is valid.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  synchronous, active-low; low at a rising edge of clk resets the block.
REQ-006 enable  input  1  shift tick; when high in DESLOCANDO, the serial stream advances one bit.
REQ-007 entrada_valida  input  1  parallel word present on entrada_paralela.
REQ-008 entrada_paralela  input  LARGURA  parallel word to serialise.
REQ-009 entrada_pronta  output  1  block can accept a word this cycle.
REQ-010 saida_serial  output  1  current serial bit.
REQ-011 saida_valida  output  1  saida_serial carries a data bit.
REQ-012 ultimo_bit  output  1  current bit is the final bit of its word.
REQ-013 ocupado  output  1  shift in progress or holding buffer full.

Function
REQ-014 A word SHALL be accepted at a rising edge where entrada_valida and entrada_pronta are both high; no other condition accepts data.
REQ-015 entrada_pronta SHALL be the inverse of the holding-buffer-full flag, with no combinational path from entrada_valida or enable.
REQ-016 States SHALL be OCIOSO and DESLOCANDO.
REQ-017 In OCIOSO, an accepted word SHALL load directly into the shift register, clear the bit counter to 0, and enter DESLOCANDO at the same edge.
REQ-018 In DESLOCANDO, an accepted word SHALL go to the one-entry holding buffer and set buffer-full.
REQ-019 In DESLOCANDO: saida_valida=1, and saida_serial SHALL present the bit selected by counter and MSB_PRIMEIRO, driven from registers only.
REQ-020 First bit SHALL be valid in the cycle after the accepting edge, regardless of enable.
REQ-021 With enable low, the current bit and all state SHALL hold indefinitely.
REQ-022 Bit counter: width $clog2(LARGURA); increments on enable; ultimo_bit=1 when counter equals LARGURA-1.
REQ-023 On enable at the last bit, if buffer-full: load buffer into shift register, clear buffer-full and counter, stay in DESLOCANDO (zero-gap back-to-back).
REQ-024 On enable at the last bit, if buffer empty and a word is accepted at the same edge: load that word directly into the shift register and stay in DESLOCANDO.
REQ-025 On enable at the last bit, with buffer empty and no accept: return to OCIOSO.
REQ-026 In OCIOSO: saida_valida=0, ultimo_bit=0, saida_serial=NIVEL_OCIOSO.
REQ-027 ocupado SHALL be high in DESLOCANDO or while buffer-full is set.
REQ-028 Accepted words SHALL emerge in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-029 When reset is low at an edge: state=OCIOSO, counter=0, buffer-full=0, shift register and buffer cleared, and any in-flight word discarded.
REQ-030 During and after reset: entrada_pronta=1, saida_valida=0, ultimo_bit=0, ocupado=0, saida_serial=NIVEL_OCIOSO.
REQ-031 Reset SHALL take priority over accept and enable at the same edge.

Structure
REQ-032 The state enum (OCIOSO, DESLOCANDO) SHALL live in shared package piso_pkg.
REQ-033 The holding buffer SHALL be sub-module buffer_palavra (one-entry register with full flag); the rest stays in one module.

Verification
REQ-034 LARGURA=8, MSB_PRIMEIRO=0, enable=1, accept 8'h1E -> serial 0,1,1,1,1,0,0,0 on eight consecutive cycles, ultimo_bit only on the 8th, then OCIOSO.
REQ-035 MSB_PRIMEIRO=1, accept 8'h1E -> serial 0,0,0,1,1,1,1,0.
REQ-036 Accept 8'h1E, then 8'hFF on the 3rd bit -> entrada_pronta=0 until the 8th bit, 16 contiguous valid bits, no idle cycle between words.
REQ-037 enable toggling 1,0,0,1,... during 8'hA5 -> each bit held while enable=0, sequence unchanged, saida_valida stays 1.
REQ-038 reset low on the 4th bit of 8'hFF -> next cycle saida_valida=0, saida_serial=NIVEL_OCIOSO, entrada_pronta=1; a following 8'h01 serialises cleanly.
REQ-039 Accept at the same edge as the last-bit enable with buffer empty -> new word's first bit in the next cycle, no gap.
